bcd_to_bin: RTL and testbench
=============================

BCD_TO_BIN -- requirements
Module: bcd_to_bin

Interface
REQ-001 Parameter DIGITS, default 4: number of packed BCD digits in the input word.
REQ-002 Parameter BIN_W, default 14: binary result width; it SHALL be at least ceil(log2(10^DIGITS)).
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port start, input, 1 bit: conversion request, sampled only while ready=1.
REQ-006 Port bcd_in, input, 4*DIGITS bits: packed BCD operand, most significant digit in the top nibble.
REQ-007 Port ready, output, 1 bit: high while idle and able to accept start.
REQ-008 Port done, output, 1 bit: one-cycle pulse when the result outputs update.
REQ-009 Port bin_out, output, BIN_W bits: binary value of the last accepted operand.
REQ-010 Port fout, output, 4 bits: [3]=Z (bin_out==0), [2]=E (an invalid digit was found), [1:0]=0.

Function
REQ-011 The state machine SHALL have three states: IDLE, CONV and DONE.
REQ-012 In IDLE with start=1, the block SHALL latch bcd_in into a shift register, clear the accumulator, load digit counter DIGITS-1, clear the error bit, and go to CONV.
REQ-013 In CONV, each cycle SHALL consume the top nibble d: acc <= acc*10 + d, computed at BIN_W+4 bits, then truncated to BIN_W bits.
REQ-014 In CONV, each cycle SHALL shift the register left by 4 bits and decrement the counter.
REQ-015 In CONV, if d > 9 the error bit SHALL be set and remain set for the rest of the operation.
REQ-016 When the counter is 0 in CONV, the FSM SHALL go to DONE after that cycle's accumulate.
REQ-017 In DONE, bin_out SHALL load acc, or 0 if the error bit is set.
REQ-018 In DONE, fout[2] SHALL load the error bit and fout[3] SHALL load (loaded bin_out==0).
REQ-019 In DONE, done SHALL be 1 for exactly that one cycle and the FSM SHALL return to IDLE.
REQ-020 Latency: start accepted at edge T SHALL produce done=1 in the cycle after edge T+DIGITS+1, i.e. DIGITS+2 edges including acceptance.
REQ-021 ready SHALL be 1 only in IDLE.
REQ-022 start while ready=0 SHALL be ignored, not queued.
REQ-023 bin_out and fout SHALL hold their values until the next DONE.
REQ-024 A new start SHALL be accepted in the cycle immediately after DONE, giving a throughput of one conversion per DIGITS+2 cycles.
REQ-025 An invalid digit SHALL NOT abort the conversion; the cycle count SHALL be identical to a valid operand.
REQ-026 A change on bcd_in after acceptance SHALL have no effect on the conversion in progress.
REQ-027 Digit 0 in any position SHALL be handled identically to the other digits; leading zeros SHALL NOT be skipped.

Reset
REQ-028 reset_n=0 SHALL, asynchronously, force state IDLE, ready=1, done=0, bin_out=0, fout=4'b1000, and clear the accumulator, shift register, counter and error bit.
REQ-029 A reset asserted mid-CONV SHALL discard the operation, and no done SHALL follow.
REQ-030 After reset_n rises, the first start SHALL be accepted on the next rising edge.

Verification
REQ-031 The bench SHALL cover: bcd_in=16'h9999 with start -> exactly 6 cycles later done=1, bin_out=14'd9999 (0x270F), fout=4'b0000.
REQ-032 The bench SHALL cover: bcd_in=16'h0000 -> done, bin_out=0, fout=4'b1000; and 16'h0001 -> bin_out=1, fout=4'b0000.
REQ-033 The bench SHALL cover: bcd_in=16'h12A4 -> done at the normal latency, bin_out=0, fout=4'b1100; and 16'hF000 -> fout[2]=1.
REQ-034 The bench SHALL cover: start with 16'h0042, start held high with bcd_in=16'h7777 during CONV -> the result is 42 and no second done occurs until start is re-sampled in IDLE.
REQ-035 The bench SHALL cover: reset_n pulsed low two cycles into a conversion of 16'h5555 -> ready=1, bin_out=0, no done; a following start with 16'h0100 -> bin_out=100.
REQ-036 The bench SHALL cover: back-to-back starts with 16'h1234 then 16'h4321, the second accepted the cycle after the first done -> bin_out 1234 then 4321, done pulses 6 cycles apart.

Source files
------------

// File: rtl/bcd_to_bin.sv
// rtl/bcd_to_bin.sv - sequential packed-BCD to binary converter, one digit per cycle
module bcd_to_bin #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  ready,
    output logic                  done,
    output logic [BIN_W-1:0]      bin_out,
    output logic [3:0]            fout
);

    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [4*DIGITS-1:0]   sreg_q, sreg_d;
    logic [BIN_W-1:0]      acc_q, acc_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic                  ready_q, ready_d;
    logic                  done_q, done_d;
    logic [BIN_W-1:0]      bin_q, bin_d;
    logic [3:0]            fout_q, fout_d;

    logic [3:0]            digit;
    logic [BIN_W-1:0]      acc_next;

    // Next-state and datapath: consume the top nibble each CONV cycle, publish results in DONE
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        done_d  = 1'b0;
        bin_d   = bin_q;
        fout_d  = fout_q;

        digit    = sreg_q[4*DIGITS-1 -: 4];
        // acc*10 + d evaluated modulo 2^BIN_W; identical to computing wider and truncating
        acc_next = (acc_q << 3) + (acc_q << 1) + BIN_W'(digit);

        case (state_q)
            IDLE: begin
                if (start) begin
                    sreg_d  = bcd_in;
                    acc_d   = '0;
                    cnt_d   = CNT_W'(DIGITS - 1);
                    err_d   = 1'b0;
                    state_d = CONV;
                end
            end
            CONV: begin
                acc_d  = acc_next;
                sreg_d = sreg_q << 4;
                cnt_d  = cnt_q - CNT_W'(1);
                // an invalid digit is remembered but the conversion runs its full length
                if (digit > 4'd9) begin
                    err_d = 1'b1;
                end
                if (cnt_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bin_d   = err_q ? '0 : acc_q;
                fout_d  = {(bin_d == '0), err_q, 2'b00};
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
    end

    // State and registered outputs; reset returns to an idle, zero-result condition
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            bin_q   <= '0;
            fout_q  <= 4'b1000;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            bin_q   <= bin_d;
            fout_q  <= fout_d;
        end
    end

    assign ready   = ready_q;
    assign done    = done_q;
    assign bin_out = bin_q;
    assign fout    = fout_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
// tb/tb_bcd_to_bin.sv - directed self-checking bench for bcd_to_bin
module tb_bcd_to_bin;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [15:0] bcd_in;
    logic        ready;
    logic        done;
    logic [13:0] bin_out;
    logic [3:0]  fout;

    int n_assert;
    int n_fail;
    int lat;
    int seen;

    bcd_to_bin #(.DIGITS(4), .BIN_W(14)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .bcd_in  (bcd_in),
        .ready   (ready),
        .done    (done),
        .bin_out (bin_out),
        .fout    (fout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge; returns at the falling edge where done is seen.
    // lat counts rising edges from acceptance through the edge that raised done.
    task automatic do_conv(input logic [15:0] v, input logic [15:0] alt, input bit hold,
                           output int latency);
        latency = 99;
        start  = 1'b1;
        bcd_in = v;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bcd_in = alt;
                if (!hold) start = 1'b0;
            end
            if (done) begin
                latency = k;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic count_done(input int cycles, output int hits);
        hits = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (done) hits++;
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        start    = 1'b0;
        bcd_in   = 16'h0000;

        // reset state
        @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_bin", 32'(bin_out), 32'd0);
        chk("rst_fout", 32'(fout), 32'b1000);
        reset_n = 1'b1;
        @(negedge clk);

        // 9999: six edges to done, exact value, pulse lasts one cycle
        do_conv(16'h9999, 16'h0000, 1'b0, lat);
        chk("9999_lat", 32'(lat), 32'd6);
        chk("9999_bin", 32'(bin_out), 32'd9999);
        chk("9999_fout", 32'(fout), 32'b0000);
        chk("9999_ready_at_done", 32'(ready), 32'd1);
        @(negedge clk);
        chk("9999_done_one_cycle", 32'(done), 32'd0);
        chk("9999_bin_hold", 32'(bin_out), 32'd9999);

        // all zeros and leading zeros
        do_conv(16'h0000, 16'h1111, 1'b0, lat);
        chk("0000_lat", 32'(lat), 32'd6);
        chk("0000_bin", 32'(bin_out), 32'd0);
        chk("0000_fout", 32'(fout), 32'b1000);
        @(negedge clk);
        do_conv(16'h0001, 16'h9999, 1'b0, lat);
        chk("0001_lat", 32'(lat), 32'd6);
        chk("0001_bin", 32'(bin_out), 32'd1);
        chk("0001_fout", 32'(fout), 32'b0000);
        @(negedge clk);

        // invalid digits: full latency, zero result, Z and E set
        do_conv(16'h12A4, 16'h0000, 1'b0, lat);
        chk("12A4_lat", 32'(lat), 32'd6);
        chk("12A4_bin", 32'(bin_out), 32'd0);
        chk("12A4_fout", 32'(fout), 32'b1100);
        @(negedge clk);
        do_conv(16'hF000, 16'h0000, 1'b0, lat);
        chk("F000_lat", 32'(lat), 32'd6);
        chk("F000_err", 32'(fout[2]), 32'd1);
        chk("F000_bin", 32'(bin_out), 32'd0);
        @(negedge clk);

        // start held high with changed bcd_in during CONV
        do_conv(16'h0042, 16'h7777, 1'b1, lat);
        chk("0042_lat", 32'(lat), 32'd6);
        chk("0042_bin", 32'(bin_out), 32'd42);
        count_done(10, seen);
        chk("0042_no_second_done", 32'(seen), 32'd0);
        chk("0042_bin_hold", 32'(bin_out), 32'd42);

        // asynchronous reset two cycles into a conversion
        start  = 1'b1;
        bcd_in = 16'h5555;
        @(negedge clk);
        start = 1'b0;
        chk("5555_busy", 32'(ready), 32'd0);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midrst_ready", 32'(ready), 32'd1);
        chk("midrst_bin", 32'(bin_out), 32'd0);
        chk("midrst_fout", 32'(fout), 32'b1000);
        @(negedge clk);
        reset_n = 1'b1;
        count_done(10, seen);
        chk("midrst_no_done", 32'(seen), 32'd0);
        do_conv(16'h0100, 16'h0000, 1'b0, lat);
        chk("0100_lat", 32'(lat), 32'd6);
        chk("0100_bin", 32'(bin_out), 32'd100);
        @(negedge clk);

        // back-to-back, second start in the done cycle
        do_conv(16'h1234, 16'h0000, 1'b0, lat);
        chk("1234_lat", 32'(lat), 32'd6);
        chk("1234_bin", 32'(bin_out), 32'd1234);
        do_conv(16'h4321, 16'h0000, 1'b0, lat);
        chk("4321_spacing", 32'(lat), 32'd6);
        chk("4321_bin", 32'(bin_out), 32'd4321);
        chk("4321_fout", 32'(fout), 32'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
